// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex driver for a bank of seven-segment digits.
// Scans one digit per REFRESH_CYCLES clocks, swaps in newly loaded values
// only on frame boundaries (no tearing), and optionally blanks leading zeros.
module hex_display_scanner #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_CYCLES = 50000,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int PW = $clog2(REFRESH_CYCLES);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_CYCLES - 1);
    localparam logic [DW-1:0] DIGIT_MAX = DW'(DIGITS - 1);
    localparam logic          OFF       = ACTIVE_LOW;

    logic [PW-1:0]         presc_q, presc_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
    logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
    logic                  frame_done_q;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;

    logic                  tick;
    logic                  boundary;
    logic [DIGITS-1:0]     zero_from;
    logic [3:0]            nib;
    logic                  nib_dp;
    logic                  blank;
    logic [6:0]            seg_log;

    assign tick     = (presc_q == PRESC_MAX);
    assign boundary = tick && (digit_q == DIGIT_MAX);

    // Prescaler, digit index and capture/display register next-state.
    always_comb begin
        presc_d     = presc_q + PW'(1);
        digit_d     = digit_q;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_flag_d = pend_flag_q;
        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;
        if (tick) begin
            presc_d = '0;
            digit_d = (digit_q == DIGIT_MAX) ? '0 : digit_q + DW'(1);
        end
        if (load) begin
            pend_val_d  = value;
            pend_dp_d   = dp_in;
            pend_flag_d = 1'b1;
        end
        // A load on the boundary edge bypasses pending and lands in display.
        if (boundary) begin
            if (load) begin
                disp_val_d  = value;
                disp_dp_d   = dp_in;
                pend_flag_d = 1'b0;
            end else if (pend_flag_q) begin
                disp_val_d  = pend_val_q;
                disp_dp_d   = pend_dp_q;
                pend_flag_d = 1'b0;
            end
        end
    end

    // Leading-zero map: zero_from[i] is set when nibbles i..DIGITS-1 are all zero.
    always_comb begin
        logic acc;
        acc       = 1'b1;
        zero_from = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            acc = acc & (disp_val_q[4*(DIGITS-1-k) +: 4] == 4'h0);
            zero_from[DIGITS-1-k] = acc;
        end
    end

    // Select the active digit, decode it and apply blanking/polarity.
    always_comb begin
        nib    = 4'h0;
        nib_dp = 1'b0;
        blank  = 1'b0;
        an_d   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digit_q == DW'(i)) begin
                nib     = disp_val_q[4*i +: 4];
                nib_dp  = disp_dp_q[i];
                blank   = blank_lz && (i != 0) && zero_from[i];
                an_d[i] = 1'b1;
            end
        end
        case (nib)
            4'h0: seg_log = 7'h3F;
            4'h1: seg_log = 7'h06;
            4'h2: seg_log = 7'h5B;
            4'h3: seg_log = 7'h4F;
            4'h4: seg_log = 7'h66;
            4'h5: seg_log = 7'h6D;
            4'h6: seg_log = 7'h7D;
            4'h7: seg_log = 7'h07;
            4'h8: seg_log = 7'h7F;
            4'h9: seg_log = 7'h6F;
            4'hA: seg_log = 7'h77;
            4'hB: seg_log = 7'h7C;
            4'hC: seg_log = 7'h39;
            4'hD: seg_log = 7'h5E;
            4'hE: seg_log = 7'h79;
            default: seg_log = 7'h71;
        endcase
        if (blank) begin
            seg_log = '0;
            nib_dp  = 1'b0;
        end
        seg_d = ACTIVE_LOW ? ~seg_log : seg_log;
        dp_d  = ACTIVE_LOW ? ~nib_dp : nib_dp;
        an_d  = ACTIVE_LOW ? ~an_d : an_d;
    end

    // State and output registers; reset leaves every output inactive.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            presc_q      <= '0;
            digit_q      <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_flag_q  <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            frame_done_q <= 1'b0;
            seg_q        <= {7{OFF}};
            dp_q         <= OFF;
            an_q         <= {DIGITS{OFF}};
        end else begin
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_flag_q  <= pend_flag_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            frame_done_q <= boundary;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign busy       = pend_flag_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: a cycle-count based reference model predicts
// every output each cycle, plus literal spot checks of known display states.
module tb_hex_display_scanner;

    localparam int D  = 4;
    localparam int R  = 4;
    localparam bit AL = 1'b1;

    logic          clk = 1'b0;
    logic          n_reset = 1'b1;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic          load = 1'b0;
    logic          blank_lz = 1'b0;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_done;
    logic          busy;

    int compared = 0;
    int mismatched = 0;

    hex_display_scanner #(.DIGITS(D), .REFRESH_CYCLES(R), .ACTIVE_LOW(AL)) dut (
        .clk(clk), .n_reset(n_reset), .value(value), .dp_in(dp_in),
        .load(load), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: position in the scan is derived from the number of
    // clock edges since reset, not from any counter structure.
    int unsigned n;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_disp_dp, m_pend_dp;
    bit          m_flag;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd, e_busy;
    logic [3:0]  e_an;

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            n = 0; m_disp = '0; m_pend = '0; m_disp_dp = '0; m_pend_dp = '0; m_flag = 0;
            e_seg = {7{AL}}; e_dp = AL; e_an = {4{AL}}; e_fd = 1'b0; e_busy = 1'b0;
        end else begin
            int d;
            bit bnd, blk;
            logic [3:0]  nb;
            logic [6:0]  ls;
            logic        ld;
            logic [15:0] upper;
            d     = (n / R) % D;
            bnd   = (n % (R * D)) == (R * D - 1);
            upper = m_disp >> (4 * d);
            nb    = upper[3:0];
            blk   = blank_lz && (d > 0) && (upper == 16'h0);
            ls    = blk ? 7'h00 : seg_tab[nb];
            ld    = blk ? 1'b0 : m_disp_dp[d];
            e_seg = AL ? ~ls : ls;
            e_dp  = AL ? ~ld : ld;
            e_an  = AL ? ~(4'b0001 << d) : (4'b0001 << d);
            e_fd  = bnd;
            if (load) begin
                m_pend = value; m_pend_dp = dp_in; m_flag = 1;
            end
            if (bnd) begin
                if (load) begin
                    m_disp = value; m_disp_dp = dp_in; m_flag = 0;
                end else if (m_flag) begin
                    m_disp = m_pend; m_disp_dp = m_pend_dp; m_flag = 0;
                end
            end
            e_busy = m_flag;
            n++;
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("seg", {9'h0, seg}, {9'h0, e_seg});
        check("dp", {15'h0, dp}, {15'h0, e_dp});
        check("an", {12'h0, an}, {12'h0, e_an});
        check("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
        check("busy", {15'h0, busy}, {15'h0, e_busy});
    end

    task automatic wait_fd(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_done !== 1'b1 && k < 40);
        if (frame_done !== 1'b1) check({nm, "_fd_timeout"}, 16'h0, 16'h1);
    endtask

    task automatic check_digit(input int d, input logic [6:0] es, input logic edp, input string nm);
        logic [3:0] want_an;
        int k;
        want_an = ~(4'b0001 << d);
        k = 0;
        while (an !== want_an && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (an !== want_an) begin
            check({nm, "_an_timeout"}, {12'h0, an}, {12'h0, want_an});
        end else begin
            check({nm, "_seg"}, {9'h0, seg}, {9'h0, es});
            check({nm, "_dp"}, {15'h0, dp}, {15'h0, edp});
        end
    endtask

    task automatic wait_phase(input int ph);
        int k;
        k = 0;
        while ((n % (R * D)) != ph && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int pulses;
        int k;
        #2 n_reset = 1'b0;
        #20;
        check("rst_seg", {9'h0, seg}, 16'h007F);
        check("rst_an", {12'h0, an}, 16'h000F);
        check("rst_dp", {15'h0, dp}, 16'h0001);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("first_an", {12'h0, an}, 16'h000E);
        check("first_seg", {9'h0, seg}, 16'h0040);

        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) pulses++;
        end
        check("fd_pulses_32cyc", pulses[15:0], 16'd2);

        // Mid-frame load of 1A2F: held off until the next frame boundary.
        value = 16'h1A2F; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("busy_after_load", {15'h0, busy}, 16'h0001);
        wait_fd("load1a2f");
        check("busy_after_frame", {15'h0, busy}, 16'h0000);
        check_digit(0, ~7'h71, 1'b1, "d0_F");
        check_digit(1, ~7'h5B, 1'b1, "d1_2");
        check_digit(2, ~7'h77, 1'b1, "d2_A");
        check_digit(3, ~7'h06, 1'b1, "d3_1");

        // Leading-zero blanking overrides dp requests on dark digits.
        value = 16'h0005; dp_in = 4'b0110; blank_lz = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fd("load0005");
        check_digit(0, ~7'h6D, 1'b1, "lz_d0");
        check_digit(1, 7'h7F, 1'b1, "lz_d1");
        check_digit(2, 7'h7F, 1'b1, "lz_d2");
        check_digit(3, 7'h7F, 1'b1, "lz_d3");
        blank_lz = 1'b0;
        check_digit(0, ~7'h6D, 1'b1, "nolz_d0");
        check_digit(1, ~7'h3F, 1'b0, "nolz_d1");
        check_digit(2, ~7'h3F, 1'b0, "nolz_d2");

        // Boundary-edge load wins over an earlier pending value.
        wait_phase(5);
        value = 16'h1234; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_phase(15);
        value = 16'hBEEF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("bnd_busy", {15'h0, busy}, 16'h0000);
        check("bnd_fd", {15'h0, frame_done}, 16'h0001);
        check_digit(0, ~7'h71, 1'b1, "beef_d0");
        check_digit(1, ~7'h79, 1'b1, "beef_d1");
        check_digit(2, ~7'h79, 1'b1, "beef_d2");
        check_digit(3, ~7'h7C, 1'b1, "beef_d3");

        // Randomized traffic checked by the per-cycle model.
        for (int i = 0; i < 800; i++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 3))
                0: mask = 16'h000F;
                1: mask = 16'h00FF;
                2: mask = 16'h0FFF;
                default: mask = 16'hFFFF;
            endcase
            value = 16'($urandom) & mask;
            dp_in = 4'($urandom);
            load  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            @(negedge clk);
        end
        load = 1'b0;

        // Reset mid-digit-2 with a capture pending: everything is discarded.
        k = 0;
        while (((n / R) % D) != 1 && k < 40) begin @(negedge clk); k++; end
        value = 16'h7777; dp_in = 4'b1111; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        k = 0;
        while (!(((n / R) % D) == 2 && (n % R) == 1) && k < 40) begin @(negedge clk); k++; end
        #2 n_reset = 1'b0;
        #1;
        check("midrst_seg", {9'h0, seg}, 16'h007F);
        check("midrst_an", {12'h0, an}, 16'h000F);
        check("midrst_dp", {15'h0, dp}, 16'h0001);
        check("midrst_busy", {15'h0, busy}, 16'h0000);
        check("midrst_fd", {15'h0, frame_done}, 16'h0000);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("restart_an", {12'h0, an}, 16'h000E);
        check("restart_seg", {9'h0, seg}, 16'h0040);
        check("restart_busy", {15'h0, busy}, 16'h0000);
        for (int i = 0; i < 20; i++) @(negedge clk);
        check_digit(3, ~7'h3F, 1'b1, "restart_d3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
